// File: rtl/vop2_issue_ctrl.sv
// vop2_issue_ctrl: sequences one VOP2 instruction at a time through operand
// reads, ALU issue, latency wait and VGPR writeback. Wave64 instructions run
// as two wave32 halves (low half first). Every cycle of a half costs the same
// number of clocks, so the second half starts one turnaround cycle after the
// first writeback, just as a new instruction would after IDLE.
//
// Handshake: an instruction transfers on a rising clk edge where
// inst_valid && inst_ready. inst_ready is high only while IDLE. The issuer
// keeps inst_valid and the instruction stable until that edge. While busy,
// inst_valid is ignored.
module vop2_issue_ctrl #(
  parameter int ALU_LATENCY = 4,
  parameter int WID_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_valid,
  output logic             inst_ready,
  input  logic [31:0]      inst,
  input  logic             inst_wave64,
  input  logic [WID_W-1:0] inst_wid,
  output logic             rf_rd_en,
  output logic [7:0]       rf_rd_addr,
  output logic             rf_rd_sel,
  output logic             rf_rd_half,
  output logic             alu_issue,
  output logic [5:0]       alu_op,
  output logic             alu_src0_vgpr,
  output logic [8:0]       alu_src0_code,
  output logic             alu_half,
  output logic             wb_en,
  output logic [7:0]       wb_addr,
  output logic             wb_half,
  output logic [WID_W-1:0] wb_wid,
  output logic             busy,
  output logic             illegal,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_RD1  = 3'd2,
    S_EXEC = 3'd3,
    S_WAIT = 3'd4,
    S_WB   = 3'd5,
    S_NEXT = 3'd6   // turnaround between wave64 halves
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(ALU_LATENCY - 1);

  state_t           state, state_n;
  logic [3:0]       cnt, cnt_n;
  logic             half, half_n;
  logic [5:0]       op_q;
  logic [7:0]       vdst_q, vsrc1_q;
  logic [8:0]       src0_q;
  logic             w64_q;
  logic [WID_W-1:0] wid_q;

  logic             hs, bad;
  logic [5:0]       op_n;
  logic [7:0]       vdst_n, vsrc1_n;
  logic [8:0]       src0_n;
  logic [WID_W-1:0] wid_n;

  assign hs  = inst_valid && inst_ready;
  // Bit 31 set is a different encoding; 3E/3F opcodes belong to VOPC/VOP1.
  assign bad = inst[31] || (inst[30:25] == 6'h3E) || (inst[30:25] == 6'h3F);

  // Field values as they will be once this edge completes.
  assign op_n    = hs ? inst[30:25] : op_q;
  assign vdst_n  = hs ? inst[24:17] : vdst_q;
  assign vsrc1_n = hs ? inst[16:9]  : vsrc1_q;
  assign src0_n  = hs ? inst[8:0]   : src0_q;
  assign wid_n   = hs ? inst_wid    : wid_q;

  // Next-state, latency counter and lane-half sequencing.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    half_n  = half;
    case (state)
      S_IDLE: begin
        half_n = 1'b0;
        if (hs && !bad) state_n = S_RD0;
      end
      S_RD0:  state_n = S_RD1;
      S_RD1:  state_n = S_EXEC;
      S_EXEC: begin
        if (ALU_LATENCY == 1) begin
          state_n = S_WB;
        end else begin
          state_n = S_WAIT;
          cnt_n   = LAT_M1;
        end
      end
      S_WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) state_n = S_WB;
      end
      S_WB: begin
        if (w64_q && !half) begin
          half_n  = 1'b1;
          state_n = S_NEXT;
        end else begin
          half_n  = 1'b0;
          state_n = S_IDLE;
        end
      end
      S_NEXT: state_n = S_RD0;
      default: begin
        state_n = S_IDLE;
        half_n  = 1'b0;
      end
    endcase
  end

  // State, latched fields and all outputs, registered against the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      half          <= 1'b0;
      op_q          <= '0;
      vdst_q        <= '0;
      vsrc1_q       <= '0;
      src0_q        <= '0;
      w64_q         <= 1'b0;
      wid_q         <= '0;
      inst_ready    <= 1'b0;
      rf_rd_en      <= 1'b0;
      rf_rd_addr    <= '0;
      rf_rd_sel     <= 1'b0;
      rf_rd_half    <= 1'b0;
      alu_issue     <= 1'b0;
      alu_op        <= '0;
      alu_src0_vgpr <= 1'b0;
      alu_src0_code <= '0;
      alu_half      <= 1'b0;
      wb_en         <= 1'b0;
      wb_addr       <= '0;
      wb_half       <= 1'b0;
      wb_wid        <= '0;
      busy          <= 1'b0;
      illegal       <= 1'b0;
      dbg_state     <= S_IDLE;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      half  <= half_n;
      if (hs) begin
        op_q    <= op_n;
        vdst_q  <= vdst_n;
        vsrc1_q <= vsrc1_n;
        src0_q  <= src0_n;
        w64_q   <= inst_wave64;
        wid_q   <= wid_n;
      end
      inst_ready    <= (state_n == S_IDLE);
      busy          <= (state_n != S_IDLE);
      illegal       <= hs && bad;
      rf_rd_en      <= ((state_n == S_RD0) && src0_n[8]) || (state_n == S_RD1);
      rf_rd_addr    <= (state_n == S_RD1) ? vsrc1_n :
                       ((state_n == S_RD0) && src0_n[8]) ? src0_n[7:0] : 8'd0;
      rf_rd_sel     <= (state_n == S_RD1);
      rf_rd_half    <= half_n;
      alu_issue     <= (state_n == S_EXEC);
      alu_op        <= (state_n != S_IDLE) ? op_n : 6'd0;
      alu_src0_vgpr <= (state_n != S_IDLE) && src0_n[8];
      alu_src0_code <= (state_n != S_IDLE) ? src0_n : 9'd0;
      alu_half      <= half_n;
      wb_en         <= (state_n == S_WB);
      wb_addr       <= (state_n == S_WB) ? vdst_n : 8'd0;
      wb_half       <= half_n;
      wb_wid        <= (state_n == S_WB) ? wid_n : '0;
      dbg_state     <= state_n;
    end
  end

endmodule

// File: tb/tb_vop2_issue_ctrl.sv
// Bench for vop2_issue_ctrl: one instance with ALU_LATENCY=4 (a_*) and one
// with ALU_LATENCY=1 (b_*). Expected per-cycle output bundles come from the
// cycle-timing rules applied to hand-decoded instruction fields.
module tb_vop2_issue_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---- instance A: ALU_LATENCY = 4
  logic a_valid, a_ready, a_w64;
  logic [31:0] a_inst;
  logic [3:0] a_wid, a_wb_wid;
  logic a_rd_en, a_rd_sel, a_rd_half, a_issue, a_vg, a_ahalf, a_wb_en, a_wb_half, a_busy, a_ill;
  logic [7:0] a_rd_addr, a_wb_addr;
  logic [5:0] a_op;
  logic [8:0] a_code;
  logic [2:0] a_dbg;

  // ---- instance B: ALU_LATENCY = 1
  logic b_valid, b_ready, b_w64;
  logic [31:0] b_inst;
  logic [3:0] b_wid, b_wb_wid;
  logic b_rd_en, b_rd_sel, b_rd_half, b_issue, b_vg, b_ahalf, b_wb_en, b_wb_half, b_busy, b_ill;
  logic [7:0] b_rd_addr, b_wb_addr;
  logic [5:0] b_op;
  logic [8:0] b_code;
  logic [2:0] b_dbg;

  vop2_issue_ctrl #(.ALU_LATENCY(4), .WID_W(4)) dut_a (
    .clk(clk), .rst(rst), .inst_valid(a_valid), .inst_ready(a_ready), .inst(a_inst),
    .inst_wave64(a_w64), .inst_wid(a_wid), .rf_rd_en(a_rd_en), .rf_rd_addr(a_rd_addr),
    .rf_rd_sel(a_rd_sel), .rf_rd_half(a_rd_half), .alu_issue(a_issue), .alu_op(a_op),
    .alu_src0_vgpr(a_vg), .alu_src0_code(a_code), .alu_half(a_ahalf), .wb_en(a_wb_en),
    .wb_addr(a_wb_addr), .wb_half(a_wb_half), .wb_wid(a_wb_wid), .busy(a_busy),
    .illegal(a_ill), .dbg_state(a_dbg)
  );

  vop2_issue_ctrl #(.ALU_LATENCY(1), .WID_W(4)) dut_b (
    .clk(clk), .rst(rst), .inst_valid(b_valid), .inst_ready(b_ready), .inst(b_inst),
    .inst_wave64(b_w64), .inst_wid(b_wid), .rf_rd_en(b_rd_en), .rf_rd_addr(b_rd_addr),
    .rf_rd_sel(b_rd_sel), .rf_rd_half(b_rd_half), .alu_issue(b_issue), .alu_op(b_op),
    .alu_src0_vgpr(b_vg), .alu_src0_code(b_code), .alu_half(b_ahalf), .wb_en(b_wb_en),
    .wb_addr(b_wb_addr), .wb_half(b_wb_half), .wb_wid(b_wb_wid), .busy(b_busy),
    .illegal(b_ill), .dbg_state(b_dbg)
  );

  // Output bundle: {ready,busy,illegal,rd_en,rd_addr,rd_sel,rd_half,issue,
  //                 op,src0_vgpr,src0_code,alu_half,wb_en,wb_addr,wb_half,wb_wid}
  logic [45:0] a_out, b_out;
  assign a_out = {a_ready, a_busy, a_ill, a_rd_en, a_rd_addr, a_rd_sel, a_rd_half, a_issue,
                  a_op, a_vg, a_code, a_ahalf, a_wb_en, a_wb_addr, a_wb_half, a_wb_wid};
  assign b_out = {b_ready, b_busy, b_ill, b_rd_en, b_rd_addr, b_rd_sel, b_rd_half, b_issue,
                  b_op, b_vg, b_code, b_ahalf, b_wb_en, b_wb_addr, b_wb_half, b_wb_wid};

  localparam logic [45:0] READY_ONLY = {1'b1, 45'd0};

  typedef struct {
    logic [31:0] inst;
    logic        w64;
    logic [3:0]  wid;
    logic        bad;
    logic [5:0]  op;
    logic [7:0]  vdst;
    logic [7:0]  vsrc1;
    logic [8:0]  src0;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  // Expected bundle in cycle c after a handshake at the end of cycle 0.
  function automatic logic [45:0] exp_out(input vec_t v, input int c, input int lat);
    logic ready, bsy, ill, rd_en, rd_sel, half, iss, vg, wb;
    logic [7:0] rd_addr, wb_addr;
    logic [5:0] op;
    logic [8:0] code;
    logic [3:0] wid;
    int p, n, h, o;
    ready = 0; bsy = 0; ill = 0; rd_en = 0; rd_sel = 0; half = 0; iss = 0; vg = 0; wb = 0;
    rd_addr = 0; wb_addr = 0; op = 0; code = 0; wid = 0;
    p = lat + 4;
    n = v.w64 ? 2 : 1;
    if (c <= 0) begin
      ready = 1;
    end else if (v.bad) begin
      ready = 1;
      ill   = (c == 1);
    end else if (c >= n * p) begin
      ready = 1;
    end else begin
      h = c / p;
      o = c - h * p;
      bsy = 1; half = h[0]; op = v.op; vg = v.src0[8]; code = v.src0;
      if (o == 1 && v.src0[8]) begin rd_en = 1; rd_addr = v.src0[7:0]; end
      if (o == 2) begin rd_en = 1; rd_addr = v.vsrc1; rd_sel = 1; end
      if (o == 3) iss = 1;
      if (o == 3 + lat) begin wb = 1; wb_addr = v.vdst; wid = v.wid; end
    end
    return {ready, bsy, ill, rd_en, rd_addr, rd_sel, half, iss,
            op, vg, code, half, wb, wb_addr, half, wid};
  endfunction

  task automatic chk(input string nm, input int c, input logic [45:0] act, input logic [45:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, c, act, exp);
    end
  endtask

  function automatic logic [45:0] get_out(input bit b);
    return b ? b_out : a_out;
  endfunction

  task automatic drive(input bit b, input logic valid, input vec_t v);
    if (b) begin b_valid = valid; b_inst = v.inst; b_w64 = v.w64; b_wid = v.wid; end
    else   begin a_valid = valid; a_inst = v.inst; a_w64 = v.w64; a_wid = v.wid; end
  endtask

  task automatic wait_ready(input bit b, input string nm);
    int k = 0;
    while (get_out(b)[45] !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k == 40) begin
      checks++;
      failures++;
      $display("FAIL %s ready_timeout actual=0 expected=1", nm);
    end
  endtask

  task automatic run_vec(input bit b, input vec_t v, input int lat, input string nm);
    int total;
    total = v.bad ? 2 : (v.w64 ? 2 : 1) * (lat + 4);
    wait_ready(b, nm);
    chk(nm, 0, get_out(b), exp_out(v, 0, lat));
    drive(b, 1'b1, v);
    @(negedge clk);
    drive(b, 1'b0, v);
    for (int c = 1; c <= total; c++) begin
      chk(nm, c, get_out(b), exp_out(v, c, lat));
      if (c < total) @(negedge clk);
    end
  endtask

  vec_t tbl_a[7];
  vec_t tbl_b[2];

  initial begin
    // inst, w64, wid, bad, op, vdst, vsrc1, src0 (fields decoded by hand)
    tbl_a[0] = '{32'h060A0F0A, 1'b0, 4'h0, 1'b0, 6'h03, 8'h05, 8'h07, 9'h10A};
    tbl_a[1] = '{32'h060A0E05, 1'b0, 4'h3, 1'b0, 6'h03, 8'h05, 8'h07, 9'h005};
    tbl_a[2] = '{32'h060A0F0A, 1'b1, 4'h9, 1'b0, 6'h03, 8'h05, 8'h07, 9'h10A};
    tbl_a[3] = '{32'h7C000000, 1'b0, 4'h1, 1'b1, 6'h00, 8'h00, 8'h00, 9'h000};
    tbl_a[4] = '{32'h80000000, 1'b0, 4'h2, 1'b1, 6'h00, 8'h00, 8'h00, 9'h000};
    tbl_a[5] = '{32'h7E000000, 1'b1, 4'h4, 1'b1, 6'h00, 8'h00, 8'h00, 9'h000};
    tbl_a[6] = '{32'h7BFF01FF, 1'b1, 4'hF, 1'b0, 6'h3D, 8'hFF, 8'h80, 9'h1FF};
    tbl_b[0] = tbl_a[0];
    tbl_b[1] = tbl_a[6];

    drive(1'b0, 1'b0, tbl_a[0]);
    drive(1'b1, 1'b0, tbl_a[0]);

    // ---- reset: all outputs low while rst is held
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_a", 0, a_out, 46'd0);
    chk("reset_b", 0, b_out, 46'd0);
    rst = 1'b0;
    @(negedge clk);

    // ---- table-driven vectors
    for (int i = 0; i < 7; i++) run_vec(1'b0, tbl_a[i], 4, $sformatf("lat4_vec%0d", i));
    for (int i = 0; i < 2; i++) run_vec(1'b1, tbl_b[i], 1, $sformatf("lat1_vec%0d", i));

    // ---- reset in cycle 5 of a wave32 op aborts it without writeback
    wait_ready(1'b0, "rst_mid");
    drive(1'b0, 1'b1, tbl_a[0]);
    @(negedge clk);
    drive(1'b0, 1'b0, tbl_a[0]);
    for (int c = 1; c <= 5; c++) begin
      chk("rst_mid_pre", c, a_out, exp_out(tbl_a[0], c, 4));
      if (c < 5) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_zero", 6, a_out, 46'd0);
    rst = 1'b0;
    for (int c = 7; c <= 11; c++) begin
      @(negedge clk);
      chk("rst_mid_after", c, a_out, READY_ONLY);
    end

    // ---- back-to-back at ALU_LATENCY=1; a changed offer while busy is ignored
    wait_ready(1'b1, "b2b");
    chk("b2b_x", 0, b_out, exp_out(tbl_a[0], 0, 1));
    drive(1'b1, 1'b1, tbl_a[0]);
    @(negedge clk);
    drive(1'b1, 1'b1, tbl_a[1]);
    for (int c = 1; c <= 5; c++) begin
      chk("b2b_x", c, b_out, exp_out(tbl_a[0], c, 1));
      if (c < 5) @(negedge clk);
    end
    @(negedge clk);
    drive(1'b1, 1'b0, tbl_a[1]);
    for (int c = 1; c <= 5; c++) begin
      chk("b2b_y", c, b_out, exp_out(tbl_a[1], c, 1));
      if (c < 5) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
